// File: rtl/bus_master_port.sv
// Serial bus master port: arbitrates for the system bus, selects a slave,
// then shifts address and write data out or read data in, all LSB first.
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   start, rw_in      host request (sampled in IDLE), 1 = write
//   slave_id_in       target slave number (3 bits)
//   addr_in, wdata_in target address and write data
//   rdata_out         last completed read data
//   busy, done, err   status; done/err are one-cycle pulses
//   bus_req/bus_grant arbiter handshake
//   slave_sel         serial slave number to the arbiter
//   bus_valid/bus_out serial address/write-data stream
//   bus_mode          latched rw while busy
//   bus_in/rx_valid   serial read-data stream from the slave
//   slave_ready       slave select / write acknowledge
module bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw_in,
  input  logic [2:0]        slave_id_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              slave_sel,
  output logic              bus_valid,
  output logic              bus_out,
  output logic              bus_mode,
  input  logic              bus_in,
  input  logic              rx_valid,
  input  logic              slave_ready
);

  localparam int TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int MW0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MW  = (MW0 > 3) ? MW0 : 3;
  localparam int BW  = $clog2(MW);

  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [BW-1:0] SEL_LAST  = BW'(2);
  localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_W - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_REQ      = 4'd1;
  localparam logic [3:0] S_SEL      = 4'd2;
  localparam logic [3:0] S_WAIT_RDY = 4'd3;
  localparam logic [3:0] S_ADDR     = 4'd4;
  localparam logic [3:0] S_WDATA    = 4'd5;
  localparam logic [3:0] S_WAIT_ACK = 4'd6;
  localparam logic [3:0] S_RDATA    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;
  localparam logic [3:0] S_ERR      = 4'd9;

  logic [3:0]        state, state_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [TW-1:0]     tmo_cnt, tmo_n, tmo_inc;
  logic              timed, lost;
  logic              rw_q, rw_n;
  logic [2:0]        sid_q, sid_n, sid_sh;
  logic [ADDR_W-1:0] addr_q, addr_n, addr_sh;
  logic [DATA_W-1:0] wdata_q, wdata_n, wdata_sh;
  logic [DATA_W-1:0] shadow_q, shadow_n;
  logic [DATA_W-1:0] rdata_n;
  logic              busy_n, sel_n, valid_n, out_n, mode_n;

  // The timeout count includes the current cycle, so the wait ends after
  // exactly TIMEOUT cycles without the awaited event.
  assign tmo_inc = tmo_cnt + TW'(1);
  assign timed   = (tmo_inc == TMO_MAX);
  assign lost    = !bus_grant;

  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    tmo_n    = tmo_cnt;
    rw_n     = rw_q;
    sid_n    = sid_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    shadow_n = shadow_q;
    rdata_n  = rdata_out;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          rw_n     = rw_in;
          sid_n    = slave_id_in;
          addr_n   = addr_in;
          wdata_n  = wdata_in;
          shadow_n = '0;
          state_n  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant)  state_n = S_SEL;
        else if (timed) state_n = S_ERR;
        else            tmo_n   = tmo_inc;
      end
      S_SEL: begin
        if (lost)                     state_n = S_ERR;
        else if (bit_cnt == SEL_LAST) state_n = S_WAIT_RDY;
        else                          bit_n   = bit_cnt + BW'(1);
      end
      S_WAIT_RDY: begin
        if (lost)                        state_n = S_ERR;
        else if (!slave_ready && timed)  state_n = S_ERR;
        else if (slave_ready)            state_n = S_ADDR;
        else                             tmo_n   = tmo_inc;
      end
      S_ADDR: begin
        if (lost)                      state_n = S_ERR;
        else if (bit_cnt == ADDR_LAST) state_n = rw_q ? S_WDATA : S_RDATA;
        else                           bit_n   = bit_cnt + BW'(1);
      end
      S_WDATA: begin
        if (lost)                      state_n = S_ERR;
        else if (bit_cnt == DATA_LAST) state_n = S_WAIT_ACK;
        else                           bit_n   = bit_cnt + BW'(1);
      end
      S_WAIT_ACK: begin
        if (lost)                        state_n = S_ERR;
        else if (!slave_ready && timed)  state_n = S_ERR;
        else if (slave_ready)            state_n = S_DONE;
        else                             tmo_n   = tmo_inc;
      end
      S_RDATA: begin
        if (lost) begin
          state_n = S_ERR;
        end else if (rx_valid) begin
          shadow_n = shadow_q | (DATA_W'(bus_in) << bit_cnt);
          tmo_n    = '0;
          if (bit_cnt == DATA_LAST) begin
            state_n = S_DONE;
            rdata_n = shadow_n;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end else if (timed) begin
          state_n = S_ERR;
        end else begin
          tmo_n = tmo_inc;
        end
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n != state) begin
      bit_n = '0;
      tmo_n = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    sid_sh   = sid_n >> bit_n;
    addr_sh  = addr_n >> bit_n;
    wdata_sh = wdata_n >> bit_n;
    busy_n   = (state_n != S_IDLE) && (state_n != S_DONE) &&
               (state_n != S_ERR);
    sel_n    = (state_n == S_SEL) && sid_sh[0];
    valid_n  = (state_n == S_ADDR) || (state_n == S_WDATA);
    out_n    = ((state_n == S_ADDR) && addr_sh[0]) ||
               ((state_n == S_WDATA) && wdata_sh[0]);
    mode_n   = busy_n && rw_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      rw_q      <= 1'b0;
      sid_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shadow_q  <= '0;
      rdata_out <= '0;
      busy      <= 1'b0;
      bus_req   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      slave_sel <= 1'b0;
      bus_valid <= 1'b0;
      bus_out   <= 1'b0;
      bus_mode  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      tmo_cnt   <= tmo_n;
      rw_q      <= rw_n;
      sid_q     <= sid_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      shadow_q  <= shadow_n;
      rdata_out <= rdata_n;
      busy      <= busy_n;
      bus_req   <= busy_n;
      done      <= (state_n == S_DONE);
      err       <= (state_n == S_ERR);
      slave_sel <= sel_n;
      bus_valid <= valid_n;
      bus_out   <= out_n;
      bus_mode  <= mode_n;
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed self-checking bench for bus_master_port (ADDR_W=12, DATA_W=8,
// TIMEOUT=4). Inputs change and outputs are sampled on the falling edge.
module tb_bus_master_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw_in = 1'b0;
  logic [2:0] slave_id_in = '0;
  logic [11:0] addr_in = '0;
  logic [7:0] wdata_in = '0;
  logic [7:0] rdata_out;
  logic       busy, done, err, bus_req;
  logic       bus_grant = 1'b0;
  logic       slave_sel, bus_valid, bus_out, bus_mode;
  logic       bus_in = 1'b0;
  logic       rx_valid = 1'b0;
  logic       slave_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] obs;
  assign obs = {busy, bus_req, done, err, slave_sel, bus_valid, bus_out, bus_mode};

  bus_master_port #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rw_in(rw_in),
    .slave_id_in(slave_id_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .rdata_out(rdata_out), .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_grant(bus_grant), .slave_sel(slave_sel),
    .bus_valid(bus_valid), .bus_out(bus_out), .bus_mode(bus_mode),
    .bus_in(bus_in), .rx_valid(rx_valid), .slave_ready(slave_ready)
  );

  always #5 clk = ~clk;

  // Expected output vector k cycles after the start edge for a transaction
  // with immediate grant/ready: REQ(0) SEL(1-3) WAIT_RDY(4) ADDR(5-16)
  // then WDATA(17-24)/WAIT_ACK or RDATA, DONE at done_k, then idle.
  function automatic logic [7:0] exp_vec(input int k, input logic rw,
    input logic [2:0] sid, input logic [11:0] a, input logic [7:0] wd,
    input int done_k);
    logic b, r, d, e, s, v, o, m;
    {b, r, d, e, s, v, o, m} = '0;
    if (k == done_k) begin
      d = 1'b1;
    end else if (k < done_k) begin
      b = 1'b1; r = 1'b1; m = rw;
      if (k >= 1 && k <= 3) s = sid[k-1];
      else if (k >= 5 && k <= 16) begin v = 1'b1; o = a[k-5]; end
      else if (rw && k >= 17 && k <= 24) begin v = 1'b1; o = wd[k-17]; end
    end
    return {b, r, d, e, s, v, o, m};
  endfunction

  task automatic launch(input logic rw, input logic [2:0] sid,
    input logic [11:0] a, input logic [7:0] wd);
    @(negedge clk);
    start = 1'b1; rw_in = rw; slave_id_in = sid; addr_in = a; wdata_in = wd;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (obs !== 8'h00 || rdata_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_async got=%b/%h exp=00000000/00", obs, rdata_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 8'h00 || rdata_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_held got=%b/%h exp=00000000/00", obs, rdata_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL reset_release got=%b exp=00000000", obs);
    end
  endtask

  task automatic test_write;
    logic [7:0] e;
    int nd = 0;
    bus_grant = 1'b1; slave_ready = 1'b1;
    launch(1'b1, 3'd5, 12'hA5C, 8'h3C);
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      e = exp_vec(k, 1'b1, 3'd5, 12'hA5C, 8'h3C, 26);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL write k=%0d got=%b exp=%b", k, obs, e);
      end
      if (done) nd++;
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL write_done_count got=%0d exp=1", nd);
    end
  endtask

  task automatic test_read;
    logic [7:0] e;
    logic [7:0] dat;
    int nb = 0;
    dat = 8'h96;
    bus_grant = 1'b1; slave_ready = 1'b1;
    launch(1'b0, 3'd2, 12'h001, 8'h00);
    for (int k = 0; k <= 42; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      e = exp_vec(k, 1'b0, 3'd2, 12'h001, 8'h00, 41);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL read k=%0d got=%b exp=%b", k, obs, e);
      end
      if (k == 40) begin
        checks++;
        if (rdata_out !== 8'h00) begin
          errors++;
          $display("FAIL read_before_done got=%h exp=00", rdata_out);
        end
      end
      if (k == 41) begin
        checks++;
        if (rdata_out !== 8'h96) begin
          errors++;
          $display("FAIL read_data got=%h exp=96", rdata_out);
        end
      end
      if (k >= 17 && (k - 17) % 3 == 2 && nb < 8) begin
        rx_valid = 1'b1; bus_in = dat[nb]; nb++;
      end else begin
        rx_valid = 1'b0; bus_in = 1'b0;
      end
    end
  endtask

  task automatic test_grant_timeout;
    logic [7:0] e;
    bus_grant = 1'b0;
    launch(1'b1, 3'd1, 12'h000, 8'h00);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k <= 3)      e = 8'b1100_0001;
      else if (k == 4) e = 8'b0001_0000;
      else             e = 8'b0000_0000;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL grant_timeout k=%0d got=%b exp=%b", k, obs, e);
      end
    end
    bus_grant = 1'b1;
  endtask

  task automatic test_grant_loss;
    logic [7:0] e;
    bus_grant = 1'b1; slave_ready = 1'b1;
    launch(1'b0, 3'd6, 12'h0F0, 8'h00);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k <= 11)      e = exp_vec(k, 1'b0, 3'd6, 12'h0F0, 8'h00, 99);
      else if (k == 12) e = 8'b0001_0000;
      else              e = 8'b0000_0000;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL grant_loss k=%0d got=%b exp=%b", k, obs, e);
      end
      if (k >= 12) begin
        checks++;
        if (rdata_out !== 8'h96) begin
          errors++;
          $display("FAIL grant_loss_rdata k=%0d got=%h exp=96", k, rdata_out);
        end
      end
      if (k == 11) bus_grant = 1'b0;
    end
    bus_grant = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] e;
    int nd = 0;
    bus_grant = 1'b1; slave_ready = 1'b1;
    launch(1'b1, 3'd4, 12'h5A5, 8'hC3);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      e = exp_vec(k, 1'b1, 3'd4, 12'h5A5, 8'hC3, 26);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_pre k=%0d got=%b exp=%b", k, obs, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 8'h00 || rdata_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async got=%b/%h exp=00000000/00", obs, rdata_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_quiet k=%0d got=%b exp=00000000", k, obs);
      end
    end
    launch(1'b1, 3'd3, 12'h123, 8'hE7);
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      e = exp_vec(k, 1'b1, 3'd3, 12'h123, 8'hE7, 26);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_restart k=%0d got=%b exp=%b", k, obs, e);
      end
      if (done) nd++;
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL reset_mid_done_count got=%0d exp=1", nd);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] e;
    int nd = 0;
    bus_grant = 1'b1; slave_ready = 1'b1;
    launch(1'b1, 3'd1, 12'h3A7, 8'h5A);
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      e = exp_vec(k, 1'b1, 3'd1, 12'h3A7, 8'h5A, 26);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL start_ignored k=%0d got=%b exp=%b", k, obs, e);
      end
      if (done) nd++;
      if (k == 8) begin
        start = 1'b1; rw_in = 1'b0; slave_id_in = 3'd7;
        addr_in = 12'hFFF; wdata_in = 8'hFF;
      end else if (k == 26) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL start_ignored_done_count got=%0d exp=1", nd);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_grant_timeout();
    test_grant_loss();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_master_port.md
BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the serial address length in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the serial data length in bits.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum wait in cycles for grant, slave ready or read bit; the block SHALL support TIMEOUT >= 1.
REQ-004 clk  in  1  system clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  host transaction request, sampled in IDLE only.
REQ-007 rw_in  in  1  1 = write, 0 = read.
REQ-008 slave_id_in  in  3  target slave number.
REQ-009 addr_in  in  ADDR_W  target address.
REQ-010 wdata_in  in  DATA_W  write data.
REQ-011 rdata_out  out  DATA_W  last completed read data.
REQ-012 busy  out  1  high while a transaction is in progress.
REQ-013 done  out  1  one-cycle success pulse.
REQ-014 err  out  1  one-cycle failure pulse.
REQ-015 bus_req  out  1  request to the system bus arbiter.
REQ-016 bus_grant  in  1  arbiter grant for this master.
REQ-017 slave_sel  out  1  serial slave number to the arbiter, LSB first.
REQ-018 bus_valid  out  1  qualifies bus_out.
REQ-019 bus_out  out  1  serial address/write-data bit, LSB first.
REQ-020 bus_mode  out  1  copy of latched rw, valid while busy.
REQ-021 bus_in  in  1  serial read-data bit from the slave.
REQ-022 rx_valid  in  1  qualifies bus_in.
REQ-023 slave_ready  in  1  slave select/write acknowledge.

Function
REQ-024 All outputs SHALL be registered; the FSM states SHALL be IDLE, REQ, SEL, WAIT_RDY, ADDR, WDATA, WAIT_ACK, RDATA, DONE and ERR.
REQ-025 In IDLE with start=1, the block SHALL latch rw_in, slave_id_in, addr_in and wdata_in, enter REQ, and set busy=1 on that edge; start SHALL be ignored outside IDLE.
REQ-026 In REQ, bus_req SHALL be 1; bus_grant=1 SHALL advance to SEL, and TIMEOUT cycles without a grant SHALL go to ERR.
REQ-027 bus_req SHALL remain 1 from REQ through the last data state and SHALL drop to 0 on entry to DONE or ERR.
REQ-028 SEL SHALL last exactly 3 cycles, driving slave_sel = slave_id[0], [1], [2] in order; slave_sel SHALL be 0 in all other states.
REQ-029 WAIT_RDY SHALL advance to ADDR on slave_ready=1; TIMEOUT cycles without it SHALL go to ERR.
REQ-030 ADDR SHALL last ADDR_W cycles with bus_valid=1 and bus_out = addr bit k in cycle k; it SHALL then go to WDATA if rw=1, else to RDATA.
REQ-031 WDATA SHALL last DATA_W cycles with bus_valid=1 and bus_out = wdata bits LSB first, then go to WAIT_ACK.
REQ-032 WAIT_ACK SHALL go to DONE on slave_ready=1; TIMEOUT cycles without it SHALL go to ERR.
REQ-033 bus_valid and bus_out SHALL be 0 outside ADDR and WDATA.
REQ-034 In RDATA, each cycle with rx_valid=1 SHALL shift bus_in into the next bit of a shadow register, LSB first.
REQ-035 After DATA_W bits in RDATA, the block SHALL go to DONE.
REQ-036 The RDATA timeout counter SHALL restart on every rx_valid; TIMEOUT consecutive cycles without rx_valid SHALL go to ERR.
REQ-037 The timeout counter SHALL clear on every state change and SHALL be ceil(log2(TIMEOUT+1)) bits wide with no wrap; the timeout condition is count == TIMEOUT.
REQ-038 bus_grant=0 in any state from SEL through RDATA SHALL go to ERR on the next edge.
REQ-039 Priority when several events coincide SHALL be: grant loss, then timeout, then normal advance.
REQ-040 DONE SHALL last 1 cycle with done=1, busy=0 and bus_req=0, then return to IDLE.
REQ-041 On reads, rdata_out SHALL load the shadow register on entry to DONE.
REQ-042 ERR SHALL last 1 cycle with err=1, busy=0, bus_req=0 and rdata_out unchanged, then return to IDLE.
REQ-043 start=1 during DONE or ERR SHALL be ignored.

Reset
REQ-044 While reset=1, state SHALL be IDLE and every output, counter, latch and shadow register SHALL be 0, independent of clk.
REQ-045 Reset asserted mid-transaction SHALL drop bus_req, busy and bus_valid immediately and SHALL produce no done or err pulse.

Verification
REQ-046 Write: slave_id=5, addr=0xA5C, wdata=0x3C, grant and ready immediate -> slave_sel 1,0,1; bus_out streams 0xA5C then 0x3C LSB first; one done pulse; err never asserted.
REQ-047 Read: slave_id=2, addr=0x001, slave returns 0x96 with rx_valid gaps of 2 cycles -> rdata_out=0x96 on done; bus_valid=0 throughout RDATA.
REQ-048 Grant timeout: TIMEOUT=4, bus_grant held 0 -> err pulse exactly 4 cycles after REQ entry, then bus_req=0 and busy=0.
REQ-049 Grant loss: bus_grant drops in address bit 6 -> err on the next cycle, bus_valid=0 thereafter, rdata_out unchanged.
REQ-050 Reset during WDATA -> all outputs 0 immediately; a new start after reset completes normally with done.
REQ-051 start pulsed while busy and during DONE -> no second transaction; exactly one done pulse.
